vga_timing_gen: RTL

- Generates the VGA raster for the display path: a pixel-rate tick, horizontal/vertical counters, HSYNC/VSYNC, and a display-enable flag.
- Drives the pixel coordinates that the sprite renderers compare against each object's rectangle to produce RGB.
- Also provides a one-cycle vertical-blank pulse so the game logic updates ball and paddle positions outside the active region.

---
 rtl/vga_pkg.sv | 61 ++++++
 rtl/vga_timing_gen_if.sv | 55 +++++
 rtl/mod_counter.sv | 43 ++++
 rtl/vga_timing_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//   Shared timing definitions for the VGA raster generator.
//   - Position/colour width macros used by the display path (X_POS_W,
//     Y_POS_W, VGA_RGB_W). They are guarded so a project-wide config.svh can
//     predefine them.
//   - Default 640x480@60 timing, split into horizontal and vertical sets.
//   - vga_timing_t: one axis of timing {active, fp, sync, bp}.
//   - timing_total(): full period of one axis.
//   - cnt_width(): counter width for a modulus, never narrower than 1 bit.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef X_POS_W
`define X_POS_W 10
`endif
`ifndef Y_POS_W
`define Y_POS_W 10
`endif
`ifndef VGA_RGB_W
`define VGA_RGB_W 12
`endif

package vga_pkg;

  // 640x480@60 with a 25.175 MHz pixel clock.
  localparam int unsigned VGA_H_ACTIVE_DEF = 640;
  localparam int unsigned VGA_H_FP_DEF     = 16;
  localparam int unsigned VGA_H_SYNC_DEF   = 96;
  localparam int unsigned VGA_H_BP_DEF     = 48;
  localparam int unsigned VGA_V_ACTIVE_DEF = 480;
  localparam int unsigned VGA_V_FP_DEF     = 10;
  localparam int unsigned VGA_V_SYNC_DEF   = 2;
  localparam int unsigned VGA_V_BP_DEF     = 33;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_H_DEFAULT = '{
    active: VGA_H_ACTIVE_DEF, fp: VGA_H_FP_DEF,
    sync:   VGA_H_SYNC_DEF,   bp: VGA_H_BP_DEF
  };
  localparam vga_timing_t VGA_V_DEFAULT = '{
    active: VGA_V_ACTIVE_DEF, fp: VGA_V_FP_DEF,
    sync:   VGA_V_SYNC_DEF,   bp: VGA_V_BP_DEF
  };

  function automatic int unsigned timing_total(input vga_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  // A modulus of 1 still needs a 1-bit register so the port has a legal range.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
//   Raster bundle from the timing generator to the sprite renderers and game
//   logic.
//   master: the timing generator (drives everything)
//   slave : renderers / game logic (observe everything)
//
//   Signals:
//     pixel_tick_o   one-clk strobe per pixel period
//     pixel_x        active column, 0 outside the active region
//     pixel_y        active row, 0 outside the active region
//     display_on_o   current pixel is visible
//     hsync_o        horizontal sync
//     vsync_o        vertical sync
//     vblank_start_o one-clk pulse at the start of vertical blanking
//
//   Handshake: there is no valid/ready pair and no back-pressure; the raster
//   runs freely. pixel_tick_o is the only qualifier: a consumer that works
//   per pixel samples the other signals in a clk where pixel_tick_o=1. All
//   level signals hold for the whole pixel period; vblank_start_o is a single
//   clk wide and coincides with a pixel_tick_o.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface vga_timing_gen_if;

  logic                  pixel_tick_o;
  logic [`X_POS_W-1:0]   pixel_x;
  logic [`Y_POS_W-1:0]   pixel_y;
  logic                  display_on_o;
  logic                  hsync_o;
  logic                  vsync_o;
  logic                  vblank_start_o;

  modport master (
    output pixel_tick_o,
    output pixel_x,
    output pixel_y,
    output display_on_o,
    output hsync_o,
    output vsync_o,
    output vblank_start_o
  );

  modport slave (
    input pixel_tick_o,
    input pixel_x,
    input pixel_y,
    input display_on_o,
    input hsync_o,
    input vsync_o,
    input vblank_start_o
  );

endinterface

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
//   Modulo up counter with enable.
//   Parameters:
//     modulus parameter, at least 1; the count runs from 0 to one below it
//   Ports:
//     clk_i   clock
//     rst_i   synchronous active-high reset, clears the count
//     en_i    advance the count this clk
//     cnt_o   current count, cnt_width of the modulus bits
//     wrap_o  en_i in a clk where the count is at its last value (it returns
//             to 0 at the next edge)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mod_counter
  import vga_pkg::*;
#(
  parameter int unsigned MOD = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  output logic [cnt_width(MOD)-1:0] cnt_o,
  output logic                      wrap_o
);

  localparam int unsigned W = cnt_width(MOD);
  localparam logic [W-1:0] LAST = W'(MOD - 1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (en_i) begin
      cnt_o <= (cnt_o == LAST) ? '0 : cnt_o + 1'b1;
    end
  end

  // With a modulus of 1 the count is stuck at 0 == LAST, so wrap_o simply
  // follows en_i.
  assign wrap_o = en_i && (cnt_o == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   VGA raster generator: pixel-rate strobe, horizontal/vertical counters,
//   HSYNC/VSYNC, display enable, pixel coordinates and a vertical-blank pulse.
//
//   Parameters:
//     H_ACTIVE/H_FP/H_SYNC/H_BP  horizontal timing in pixels
//     V_ACTIVE/V_FP/V_SYNC/V_BP  vertical timing in lines
//     SYNC_POL                   active level of HSYNC/VSYNC (0 = active-low)
//     CLK_DIV                    system clocks per pixel (>= 1)
//
//   Ports:
//     clk_i   system clock, the only clock
//     rst_i   synchronous active-high reset; while high all outputs sit at
//             their idle values (tick 0, coords 0, display off, syncs
//             inactive, no vblank pulse)
//     vga     vga_timing_gen_if.master raster bundle
//
//   Build option:
//     VGA_PIPE_EN  when defined, display_on_o/hsync_o/vsync_o pass through a
//                  register enabled by pixel_tick_o, lagging pixel_x/pixel_y
//                  by one pixel period to line up with a registered RGB stage.
//                  When undefined all outputs describe the same pixel.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE_DEF,
  parameter int unsigned H_FP     = VGA_H_FP_DEF,
  parameter int unsigned H_SYNC   = VGA_H_SYNC_DEF,
  parameter int unsigned H_BP     = VGA_H_BP_DEF,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE_DEF,
  parameter int unsigned V_FP     = VGA_V_FP_DEF,
  parameter int unsigned V_SYNC   = VGA_V_SYNC_DEF,
  parameter int unsigned V_BP     = VGA_V_BP_DEF,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CLK_DIV  = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  vga_timing_gen_if.master vga
);

  // ---------------------------------------------------------------------------
  // Derived geometry
  // ---------------------------------------------------------------------------
  localparam vga_timing_t H_T = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vga_timing_t V_T = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};

  localparam int unsigned H_TOTAL = timing_total(H_T);
  localparam int unsigned V_TOTAL = timing_total(V_T);

  localparam int unsigned DW = cnt_width(CLK_DIV);
  localparam int unsigned HW = cnt_width(H_TOTAL);
  localparam int unsigned VW = cnt_width(V_TOTAL);
  localparam int unsigned XW = `X_POS_W;
  localparam int unsigned YW = `Y_POS_W;

  // Decode thresholds at full counter width so every compare is unsigned
  // and same-sized.
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic SYNC_ON  = SYNC_POL;
  localparam logic SYNC_OFF = ~SYNC_POL;

  // ---------------------------------------------------------------------------
  // Counter chain: divider -> h_cnt -> v_cnt
  // ---------------------------------------------------------------------------
  logic [DW-1:0] div_cnt;
  logic          div_wrap;
  logic [HW-1:0] h_cnt;
  logic          h_wrap;
  logic [VW-1:0] v_cnt;
  logic          v_wrap;
  logic          pixel_tick;
  logic          v_en;

  mod_counter #(.MOD(CLK_DIV)) u_div (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (1'b1),
    .cnt_o  (div_cnt),
    .wrap_o (div_wrap)
  );

  // The divider's terminal count is the pixel strobe. Masking with rst_i
  // keeps it low while reset is held (with CLK_DIV=1 it would otherwise be
  // stuck high).
  assign pixel_tick = div_wrap && !rst_i;

  mod_counter #(.MOD(H_TOTAL)) u_hcnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (pixel_tick),
    .cnt_o  (h_cnt),
    .wrap_o (h_wrap)
  );

  assign v_en = h_wrap && pixel_tick;

  mod_counter #(.MOD(V_TOTAL)) u_vcnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (v_en),
    .cnt_o  (v_cnt),
    .wrap_o (v_wrap)
  );

  // The end-of-frame wrap can only happen on the last pixel of a line, and
  // the strobe is exactly the divider's terminal count.
  a_frame_wrap: assert property (@(posedge clk_i) disable iff (rst_i)
    v_wrap |-> (h_wrap && pixel_tick));
  a_tick_div: assert property (@(posedge clk_i) disable iff (rst_i)
    div_wrap == (div_cnt == DIV_LAST));

  // ---------------------------------------------------------------------------
  // Decodes from the current counter values
  // ---------------------------------------------------------------------------
  logic          disp_c;
  logic          hs_c;
  logic          vs_c;
  logic          vblank_c;
  logic [XW-1:0] x_c;
  logic [YW-1:0] y_c;

  always_comb begin
    disp_c   = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    hs_c     = ((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST)) ? SYNC_ON : SYNC_OFF;
    vs_c     = ((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST)) ? SYNC_ON : SYNC_OFF;
    // First clk of the first blank line; pixel_tick qualifies it down to one
    // clk even when a pixel lasts several clks.
    vblank_c = pixel_tick && (h_cnt == '0) && (v_cnt == V_ACT_C);
    x_c      = disp_c ? XW'(h_cnt) : '0;
    y_c      = disp_c ? YW'(v_cnt) : '0;
  end

  // ---------------------------------------------------------------------------
  // Optional alignment stage for the signals that travel with RGB
  // ---------------------------------------------------------------------------
  logic disp_src;
  logic hs_src;
  logic vs_src;

`ifdef VGA_PIPE_EN
  logic disp_q;
  logic hs_q;
  logic vs_q;

  // Loads on the strobe, so the stage output changes on the same edge as the
  // counters and holds the previous pixel's decode for a full pixel period.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      disp_q <= 1'b0;
      hs_q   <= SYNC_OFF;
      vs_q   <= SYNC_OFF;
    end else if (pixel_tick) begin
      disp_q <= disp_c;
      hs_q   <= hs_c;
      vs_q   <= vs_c;
    end
  end

  assign disp_src = disp_q;
  assign hs_src   = hs_q;
  assign vs_src   = vs_q;
`else
  assign disp_src = disp_c;
  assign hs_src   = hs_c;
  assign vs_src   = vs_c;
`endif

  // ---------------------------------------------------------------------------
  // Outputs. rst_i overrides directly so the idle values appear in the same
  // clk reset is raised, not one edge later.
  // ---------------------------------------------------------------------------
  assign vga.pixel_tick_o   = pixel_tick;
  assign vga.pixel_x        = rst_i ? '0 : x_c;
  assign vga.pixel_y        = rst_i ? '0 : y_c;
  assign vga.display_on_o   = !rst_i && disp_src;
  assign vga.hsync_o        = rst_i ? SYNC_OFF : hs_src;
  assign vga.vsync_o        = rst_i ? SYNC_OFF : vs_src;
  assign vga.vblank_start_o = vblank_c;

endmodule
